// File: rtl/msx_audio_pkg.sv
// rtl/msx_audio_pkg.sv - states, widths and 16-bit saturation for the MSX audio mixer
// The DCB state exists only when MSX_MIXER_DC_BLOCK_EN is defined.
package msx_audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    SAT,
`ifdef MSX_MIXER_DC_BLOCK_EN
    DCB,
`endif
    OUT
  } mix_state_t;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7fff;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction
endpackage

// File: rtl/msx_audio_sat.sv
// rtl/msx_audio_sat.sv - signed W-bit to 16-bit saturator (W up to 32)
module msx_audio_sat
  import msx_audio_pkg::*;
#(
  parameter int W = 21
) (
  input  logic signed [W-1:0] x,
  output logic signed [15:0]  y
);
  logic signed [31:0] x_ext;

  assign x_ext = 32'(x);
  assign y     = sat16(x_ext);
endmodule

// File: rtl/msx_audio_mixer.sv
// rtl/msx_audio_mixer.sv - sequential N-channel gain/pan mixer with stereo saturation
// Defining MSX_MIXER_DC_BLOCK_EN adds a one-cycle DC-blocking stage after saturation.
module msx_audio_mixer
  import msx_audio_pkg::*;
#(
  parameter int               NCH           = 4,
  parameter logic [NCH-1:0]   UNSIGNED_MASK = '0,
  parameter int               SHIFT         = 3
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       sample_stb,
  input  logic [NCH*SAMPLE_W-1:0]    ch_in,
  input  logic [NCH*GAIN_W-1:0]      gain,
  input  logic [NCH*2-1:0]           pan,
  output logic signed [15:0]         audio_l,
  output logic signed [15:0]         audio_r,
  output logic                       audio_valid,
  output logic                       busy,
  output logic                       overrun
);
  localparam int AW = 21 + $clog2(NCH);
  localparam int IW = $clog2(NCH);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  mix_state_t state, state_nxt;

  logic [NCH*SAMPLE_W-1:0] ch_q, flip;
  logic [NCH*GAIN_W-1:0]   gain_q;
  logic [NCH*2-1:0]        pan_q;
  logic [IW-1:0]           idx;
  logic signed [AW-1:0]    acc_l, acc_r, term_x;
  logic signed [15:0]      smp;
  logic [GAIN_W-1:0]       g;
  logic [1:0]              p;
  logic signed [20:0]      prod, term;
  logic signed [15:0]      sat_l, sat_r;

  // Offset-binary channels become two's complement by flipping the MSB.
  always_comb begin
    flip = '0;
    for (int n = 0; n < NCH; n++)
      flip[n*SAMPLE_W + SAMPLE_W - 1] = UNSIGNED_MASK[n];
  end

  assign smp    = ch_q[idx*SAMPLE_W +: SAMPLE_W];
  assign g      = gain_q[idx*GAIN_W +: GAIN_W];
  assign p      = pan_q[idx*2 +: 2];
  assign prod   = 21'(smp) * 21'($signed({1'b0, g}));
  assign term   = prod >>> SHIFT;
  assign term_x = AW'(term);

  msx_audio_sat #(.W(AW)) u_sat_l (.x(acc_l), .y(sat_l));
  msx_audio_sat #(.W(AW)) u_sat_r (.x(acc_r), .y(sat_r));

`ifdef MSX_MIXER_DC_BLOCK_EN
  logic signed [15:0] x_l, x_r, xp_l, xp_r, yp_l, yp_r, y_l, y_r;
  logic signed [18:0] d_l, d_r;

  // y = x - x_prev + y_prev - y_prev/256; 19 bits hold the worst-case sum.
  assign d_l = 19'(x_l) - 19'(xp_l) + 19'(yp_l) - 19'(yp_l >>> 8);
  assign d_r = 19'(x_r) - 19'(xp_r) + 19'(yp_r) - 19'(yp_r >>> 8);

  msx_audio_sat #(.W(19)) u_dcb_l (.x(d_l), .y(y_l));
  msx_audio_sat #(.W(19)) u_dcb_r (.x(d_r), .y(y_r));
`endif

  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    audio_valid = (state == OUT);
    case (state)
      IDLE:    if (sample_stb) state_nxt = ACC;
      ACC:     if (idx == LAST) state_nxt = SAT;
`ifdef MSX_MIXER_DC_BLOCK_EN
      SAT:     state_nxt = DCB;
      DCB:     state_nxt = OUT;
`else
      SAT:     state_nxt = OUT;
`endif
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ch_q    <= '0;
      gain_q  <= '0;
      pan_q   <= '0;
      idx     <= '0;
      acc_l   <= '0;
      acc_r   <= '0;
      audio_l <= '0;
      audio_r <= '0;
      overrun <= 1'b0;
`ifdef MSX_MIXER_DC_BLOCK_EN
      x_l  <= '0;
      x_r  <= '0;
      xp_l <= '0;
      xp_r <= '0;
      yp_l <= '0;
      yp_r <= '0;
`endif
    end else begin
      if (sample_stb && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: if (sample_stb) begin
          ch_q   <= ch_in ^ flip;
          gain_q <= gain;
          pan_q  <= pan;
          idx    <= '0;
          acc_l  <= '0;
          acc_r  <= '0;
        end
        ACC: begin
          if (p[0]) acc_l <= acc_l + term_x;
          if (p[1]) acc_r <= acc_r + term_x;
          idx <= idx + 1'b1;
        end
`ifdef MSX_MIXER_DC_BLOCK_EN
        SAT: begin
          x_l <= sat_l;
          x_r <= sat_r;
        end
        DCB: begin
          audio_l <= y_l;
          audio_r <= y_r;
          xp_l    <= x_l;
          xp_r    <= x_r;
          yp_l    <= y_l;
          yp_r    <= y_r;
        end
`else
        SAT: begin
          audio_l <= sat_l;
          audio_r <= sat_r;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_msx_audio_mixer.sv
// tb/tb_msx_audio_mixer.sv - directed self-checking bench for msx_audio_mixer (ch0 offset-binary)
module tb_msx_audio_mixer;
  localparam int NCH = 4;
`ifdef MSX_MIXER_DC_BLOCK_EN
  localparam int LAT = NCH + 3;
`else
  localparam int LAT = NCH + 2;
`endif

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              sample_stb = 1'b0;
  logic [NCH*16-1:0] ch_in = '0;
  logic [NCH*4-1:0]  gain = '0;
  logic [NCH*2-1:0]  pan = '0;
  logic signed [15:0] audio_l, audio_r;
  logic              audio_valid, busy, overrun;

  int errors = 0;
  int checks = 0;
  int lat, nvalid;
  logic busy_mid;
  logic signed [15:0] got_l, got_r;

  msx_audio_mixer #(.NCH(NCH), .UNSIGNED_MASK(4'b0001), .SHIFT(3)) dut (
    .clk_sys(clk_sys), .reset(reset), .sample_stb(sample_stb),
    .ch_in(ch_in), .gain(gain), .pan(pan),
    .audio_l(audio_l), .audio_r(audio_r), .audio_valid(audio_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [15:0] u0(input logic [15:0] v);
    return v ^ 16'h8000;
  endfunction

  function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Strobe once; optionally re-strobe or pulse reset at a given cycle; inputs scrambled after snapshot.
  task automatic run_mix(input logic [63:0] ch, input logic [15:0] g, input logic [7:0] p,
                         input int stb2_cyc, input int rst_cyc);
    lat = -1; nvalid = 0; busy_mid = 1'b0; got_l = 'x; got_r = 'x;
    @(negedge clk_sys);
    ch_in = ch; gain = g; pan = p; sample_stb = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk_sys);
      sample_stb = (cyc == stb2_cyc);
      reset      = (cyc == rst_cyc);
      ch_in = {4{16'h5a5a}}; gain = '1; pan = '1;
      if (cyc == 1) busy_mid = busy;
      if (audio_valid) begin
        nvalid++;
        if (lat < 0) begin lat = cyc; got_l = audio_l; got_r = audio_r; end
      end
    end
    sample_stb = 1'b0; reset = 1'b0; ch_in = '0; gain = '0; pan = '0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_sys);
    checks++; if (audio_l !== 16'sd0) begin errors++; $display("FAIL reset_l: got %0d expected 0", audio_l); end
    checks++; if (audio_r !== 16'sd0) begin errors++; $display("FAIL reset_r: got %0d expected 0", audio_r); end
    checks++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", audio_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    run_mix(pack4(u0(16'd1000), 16'd2000, -16'sd500, 16'd0), 16'h8888, 8'hFF, 0, 0);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (got_l !== 16'sd2500) begin errors++; $display("FAIL basic_l: got %0d expected 2500", got_l); end
    checks++; if (got_r !== 16'sd2500) begin errors++; $display("FAIL basic_r: got %0d expected 2500", got_r); end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL basic_nvalid: got %0d expected 1", nvalid); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy_mid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    checks++; if (audio_l !== 16'sd2500) begin errors++; $display("FAIL basic_hold: got %0d expected 2500", audio_l); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_saturation;
    run_mix(pack4(u0(16'd30000), 16'd30000, 16'd30000, 16'd30000), 16'hFFFF, 8'hFF, 0, 0);
    checks++; if (got_l !== 16'sh7fff) begin errors++; $display("FAIL sat_pos_l: got %0d expected 32767", got_l); end
    checks++; if (got_r !== 16'sh7fff) begin errors++; $display("FAIL sat_pos_r: got %0d expected 32767", got_r); end
    run_mix(pack4(u0(-16'sd30000), -16'sd30000, -16'sd30000, -16'sd30000), 16'hFFFF, 8'hFF, 0, 0);
    checks++; if (got_l !== 16'sh8000) begin errors++; $display("FAIL sat_neg_l: got %0d expected -32768", got_l); end
    checks++; if (got_r !== 16'sh8000) begin errors++; $display("FAIL sat_neg_r: got %0d expected -32768", got_r); end
  endtask

  task automatic test_unsigned;
    run_mix(pack4(16'h8000, 16'd0, 16'd0, 16'd0), 16'h8888, 8'hFF, 0, 0);
    checks++; if (got_l !== 16'sd0) begin errors++; $display("FAIL unsigned_mid: got %0d expected 0", got_l); end
    run_mix(pack4(16'hFFFF, 16'd0, 16'd0, 16'd0), 16'h8888, 8'hFF, 0, 0);
    checks++; if (got_l !== 16'sh7fff) begin errors++; $display("FAIL unsigned_max: got %0d expected 32767", got_l); end
  endtask

  task automatic test_pan;
    run_mix(pack4(u0(16'd4000), 16'd4000, 16'd0, 16'd0), 16'h8888, 8'b00_00_10_01, 0, 0);
    checks++; if (got_l !== 16'sd4000) begin errors++; $display("FAIL pan_l: got %0d expected 4000", got_l); end
    checks++; if (got_r !== 16'sd4000) begin errors++; $display("FAIL pan_r: got %0d expected 4000", got_r); end
    run_mix(pack4(u0(16'd4000), 16'd4000, 16'd0, 16'd0), 16'h8888, 8'b00_00_00_00, 0, 0);
    checks++; if (got_l !== 16'sd0) begin errors++; $display("FAIL pan_mute_l: got %0d expected 0", got_l); end
    checks++; if (got_r !== 16'sd0) begin errors++; $display("FAIL pan_mute_r: got %0d expected 0", got_r); end
  endtask

  task automatic test_truncation;
    // -3*1>>>3 floors to -1, 7*1>>>3 to 0, and a gain of 0 silences 30000.
    run_mix(pack4(u0(-16'sd3), 16'd7, 16'd30000, 16'd0), 16'h0011, 8'b00_11_10_01, 0, 0);
    checks++; if (got_l !== 16'shFFFF) begin errors++; $display("FAIL trunc_l: got %0d expected -1", got_l); end
    checks++; if (got_r !== 16'sd0) begin errors++; $display("FAIL trunc_r: got %0d expected 0", got_r); end
  endtask

  task automatic test_overrun;
    run_mix(pack4(u0(16'd1000), 16'd2000, -16'sd500, 16'd0), 16'h8888, 8'hFF, 2, 0);
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL overrun_nvalid: got %0d expected 1", nvalid); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL overrun_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid;
    run_mix(pack4(u0(16'd1000), 16'd2000, -16'sd500, 16'd0), 16'h8888, 8'hFF, 0, 3);
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL rstmid_nvalid: got %0d expected 0", nvalid); end
    checks++; if (audio_l !== 16'sd0) begin errors++; $display("FAIL rstmid_l: got %0d expected 0", audio_l); end
    checks++; if (audio_r !== 16'sd0) begin errors++; $display("FAIL rstmid_r: got %0d expected 0", audio_r); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk_sys);
    reset = 1'b1; sample_stb = 1'b1; ch_in = {4{16'h1234}}; gain = '1; pan = '1;
    @(negedge clk_sys);
    reset = 1'b0; sample_stb = 1'b0;
    nvalid = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk_sys);
      if (audio_valid || busy) nvalid++;
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL rst_prio_activity: got %0d expected 0", nvalid); end
  endtask

  task automatic test_out_strobe;
    run_mix(pack4(u0(16'd100), 16'd0, 16'd0, 16'd0), 16'h8888, 8'hFF, LAT, 0);
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL outstb_nvalid: got %0d expected 1", nvalid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL outstb_overrun: got %b expected 1", overrun); end
  endtask

`ifdef MSX_MIXER_DC_BLOCK_EN
  task automatic test_dc_block;
    logic signed [15:0] prev;
    run_mix(pack4(u0(16'd8000), 16'd0, 16'd0, 16'd0), 16'h8888, 8'hFF, 0, 0);
    checks++; if (lat !== 7) begin errors++; $display("FAIL dcb_latency: got %0d expected 7", lat); end
    checks++; if (got_l !== 16'sd8000) begin errors++; $display("FAIL dcb_first_l: got %0d expected 8000", got_l); end
    checks++; if (got_r !== 16'sd8000) begin errors++; $display("FAIL dcb_first_r: got %0d expected 8000", got_r); end
    run_mix(pack4(u0(16'd8000), 16'd0, 16'd0, 16'd0), 16'h8888, 8'hFF, 0, 0);
    checks++; if (got_l !== 16'sd7969) begin errors++; $display("FAIL dcb_second_l: got %0d expected 7969", got_l); end
    prev = got_l;
    for (int k = 0; k < 3; k++) begin
      run_mix(pack4(u0(16'd8000), 16'd0, 16'd0, 16'd0), 16'h8888, 8'hFF, 0, 0);
      checks++;
      if (!(got_l < prev && got_l > 16'sd0)) begin
        errors++; $display("FAIL dcb_decay: got %0d expected below %0d and above 0", got_l, prev);
      end
      prev = got_l;
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef MSX_MIXER_DC_BLOCK_EN
    test_dc_block;
`else
    test_basic;
    test_saturation;
    test_unsigned;
    test_pan;
    test_truncation;
`endif
    test_overrun;
    test_reset_mid;
    test_out_strobe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
